core_seq_ctrl: RTL and testbench

- Instruction sequencer for the 8x8 core. It generates the 45-bit `inst` word and the 2-bit `inst_w` code that drive the core's weight, activation and psum memories and the PE array.
- After `start`, it runs every kernel position (kij) in turn: weight load, then activation execute, then output-FIFO drain.
- It finishes with one accumulation pass, then pulses `done`.
- It sits between the top-level testbench/host and the core, replacing hand-written instruction streams.

---
 rtl/core_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - instruction sequencer for the 8x8 core (weight load, execute, drain, accumulate)
module core_seq_ctrl #(
    parameter int row       = 8,
    parameter int col       = 8,
    parameter int nij_len   = 3,
    parameter int kij_len   = 9,
    parameter int drain_max = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [44:0] inst,
    output logic [1:0]  inst_w,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  kij_idx
);

    localparam int ACC_LEN = kij_len * nij_len;
    localparam int CW      = $clog2((ACC_LEN > row ? ACC_LEN : row) + 1);
    localparam int VW      = $clog2(nij_len + 1);
    localparam int DW      = $clog2(drain_max + 1);

    localparam logic [44:0] IDLE_WORD = 45'h00000C0000;
    localparam logic [44:0] ACC_WORD  = 45'h02000C0000;
    localparam logic [1:0]  IW_IDLE   = 2'b00;
    localparam logic [1:0]  IW_LOAD   = 2'b01;
    localparam logic [1:0]  IW_EXEC   = 2'b10;

    // col only describes the array width; nothing in the sequencer depends on it
    if (col < 1) begin : g_col_guard
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_EXEC,
        S_DRAIN,
        S_ACC,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [VW-1:0]   vcnt;
    logic [DW-1:0]   dcnt;
    logic [VW-1:0]   vcnt_inc;
    logic [DW-1:0]   dcnt_inc;

    function automatic logic [10:0] waddr(input logic [3:0] k, input logic [CW-1:0] c);
        logic [31:0] s;
        s = 32'(k) * 32'(row) + 32'(c);
        return s[10:0];
    endfunction

    function automatic logic [44:0] w_word(input logic [10:0] a);
        logic [44:0] w;
        w        = '0;
        w[44:34] = a;
        w[18]    = 1'b1;
        w[0]     = 1'b1;
        return w;
    endfunction

    function automatic logic [44:0] e_word(input logic [10:0] a);
        logic [44:0] w;
        w       = '0;
        w[17:7] = a;
        w[18]   = 1'b1;
        return w;
    endfunction

    // a valid on the exit cycle is counted before the exit compare
    always_comb begin
        vcnt_inc = vcnt;
        if (ofifo_valid && vcnt != VW'(nij_len))
            vcnt_inc = vcnt + 1'b1;
        dcnt_inc = dcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            vcnt    <= '0;
            dcnt    <= '0;
            kij_idx <= '0;
            inst    <= IDLE_WORD;
            inst_w  <= IW_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_WLOAD;
                        cnt     <= '0;
                        vcnt    <= '0;
                        dcnt    <= '0;
                        kij_idx <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        inst    <= w_word(waddr(4'd0, '0));
                        inst_w  <= IW_LOAD;
                    end
                end
                S_WLOAD: begin
                    if (cnt == CW'(row - 1)) begin
                        state  <= S_EXEC;
                        cnt    <= '0;
                        inst   <= e_word(11'd0);
                        inst_w <= IW_EXEC;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        inst <= w_word(waddr(kij_idx, cnt + 1'b1));
                    end
                end
                S_EXEC: begin
                    vcnt <= vcnt_inc;
                    if (cnt == CW'(nij_len - 1)) begin
                        state  <= S_DRAIN;
                        cnt    <= '0;
                        dcnt   <= '0;
                        inst   <= IDLE_WORD;
                        inst_w <= IW_IDLE;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        inst <= e_word(11'(cnt + 1'b1));
                    end
                end
                S_DRAIN: begin
                    if (vcnt_inc == VW'(nij_len)) begin
                        vcnt <= '0;
                        dcnt <= '0;
                        cnt  <= '0;
                        if (kij_idx == 4'(kij_len - 1)) begin
                            state <= S_ACC;
                            inst  <= ACC_WORD;
                        end else begin
                            kij_idx <= kij_idx + 1'b1;
                            state   <= S_WLOAD;
                            inst    <= w_word(waddr(kij_idx + 1'b1, '0));
                            inst_w  <= IW_LOAD;
                        end
                    end else if (dcnt_inc == DW'(drain_max)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        vcnt <= vcnt_inc;
                        dcnt <= dcnt_inc;
                    end
                end
                S_ACC: begin
                    if (cnt == CW'(ACC_LEN - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        cnt   <= '0;
                        inst  <= IDLE_WORD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    cnt    <= '0;
                    vcnt   <= '0;
                    dcnt   <= '0;
                    inst   <= IDLE_WORD;
                    inst_w <= IW_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - directed self-checking bench for core_seq_ctrl
module tb_core_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [44:0] inst;
    logic [1:0]  inst_w;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  kij_idx;

    int n_checks = 0;
    int n_errors = 0;
    int done_at;
    int done_n;

    core_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .inst_w      (inst_w),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .kij_idx     (kij_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: 3 valids from the 3rd drain cycle (D=5), stray valid in WLOAD, stray start in EXEC
    // mode 1: valid held through EXEC and DRAIN (D=1)
    // mode 2: kij 0 drains normally, then valid never comes (timeout)
    // mode 3: as mode 1, with reset asserted during ACC
    task automatic run(input int mode, input int ncyc);
        int k;
        done_at = -1;
        done_n  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            ofifo_valid = 1'b0;
            case (mode)
                0: begin
                    k = (cyc - 1) % 16;
                    ofifo_valid = (cyc <= 144 && k >= 13) || cyc == 20;
                    start = (cyc == 74);
                end
                1, 3: begin
                    k = (cyc - 1) % 12;
                    ofifo_valid = (cyc <= 108 && k >= 8);
                end
                default: ofifo_valid = (cyc >= 14 && cyc <= 16);
            endcase
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = cyc;
            end
            if (mode == 0 && cyc >= 33 && cyc <= 40) begin
                check("wload_addr", 64'(inst[44:34]), 64'(16 + cyc - 33));
                check("wload_instw", 64'(inst_w), 64'd1);
                check("wload_cen", 64'(inst[19]), 64'd0);
                check("wload_load", 64'(inst[0]), 64'd1);
            end
            if (mode == 0 && cyc >= 41 && cyc <= 43) begin
                check("exec_addr", 64'(inst[17:7]), 64'(cyc - 41));
                check("exec_instw", 64'(inst_w), 64'd2);
                check("exec_kij", 64'(kij_idx), 64'd2);
            end
            if (mode == 1 && cyc == 1)
                check("err_cleared", 64'(err), 64'd0);
            if (mode == 1 && cyc == 13) begin
                check("d1_kij", 64'(kij_idx), 64'd1);
                check("d1_addr", 64'(inst[44:34]), 64'd8);
                check("d1_instw", 64'(inst_w), 64'd1);
            end
            if (mode == 2 && cyc == 92)
                check("to_err_at_done", 64'(err), 64'd1);
            if (mode == 2 && cyc == 93) begin
                check("to_busy", 64'(busy), 64'd0);
                check("to_kij_frozen", 64'(kij_idx), 64'd1);
            end
            if (mode == 3 && cyc == 115) begin
                check("acc_inst", 64'(inst), 64'h2000C0000);
                check("acc_busy", 64'(busy), 64'd1);
            end
            if (mode == 3 && cyc == 120)
                reset = 1'b1;
            if (mode == 3 && cyc == 121) begin
                reset = 1'b0;
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_inst", 64'(inst), 64'h0C0000);
                check("rst_instw", 64'(inst_w), 64'd0);
                check("rst_kij", 64'(kij_idx), 64'd0);
            end
            if (mode != 3 && cyc == done_at + 1)
                check("busy_after_done", 64'(busy), 64'd0);
            step();
        end
        ofifo_valid = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ofifo_valid = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        check("reset_inst", 64'(inst), 64'h0C0000);
        check("reset_instw", 64'(inst_w), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_kij", 64'(kij_idx), 64'd0);
        step();

        // 9*(8+3) + 9*5 + 27 + 1
        run(0, 200);
        check("m0_done_at", 64'(done_at), 64'd172);
        check("m0_done_count", 64'(done_n), 64'd1);
        check("m0_err", 64'(err), 64'd0);

        run(2, 100);
        check("m2_done_at", 64'(done_at), 64'd92);
        check("m2_err_sticky", 64'(err), 64'd1);
        check("m2_kij", 64'(kij_idx), 64'd1);

        // 9*(8+3+1) + 27 + 1
        run(1, 150);
        check("m1_done_at", 64'(done_at), 64'd136);
        check("m1_done_count", 64'(done_n), 64'd1);
        check("m1_err", 64'(err), 64'd0);

        run(3, 125);
        check("m3_no_done", 64'(done_n), 64'd0);
        check("m3_idle_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
